// File: rtl/seg_disp_pkg.sv
// Shared segment constants, FSM state encoding and BCD-to-segment encoder for the display arbiter.
package seg_disp_pkg;

    // Active-low segment patterns, bit6=A ... bit0=G
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_OPEN
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request found scanning from ptr+1 upward, wrapping.
module rr_pick
    import seg_disp_pkg::*;
#(
    parameter int P_NREQ = 4,
    parameter int P_PW   = (P_NREQ > 1) ? $clog2(P_NREQ) : 1
) (
    input  logic [P_NREQ-1:0] req,
    input  logic [P_PW-1:0]   ptr,
    output logic [P_NREQ-1:0] gnt,
    output logic [P_PW-1:0]   idx,
    output logic              found
);

    logic [P_PW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // The pointer itself is visited last, so the current owner only wins when alone.
        for (int i = 1; i <= P_NREQ; i++) begin
            cand = P_PW'((int'(ptr) + i) % P_NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a shared two-digit seven-segment display with minimum hold time and digit scan.
// Optional leading-zero suppression of the tens digit with `define DISP_LZ_BLANK_EN.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int P_NREQ = 4,
    parameter int P_SCAN = 300_000,
    parameter int P_HOLD = 50_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [P_NREQ-1:0]     i_req,
    input  logic [P_NREQ*8-1:0]   i_bcd,
    output logic [P_NREQ-1:0]     o_gnt,
    output logic                  o_busy,
    output logic [6:0]            o_digitalTube,
    output logic                  o_sel
);

    localparam int PW = (P_NREQ > 1) ? $clog2(P_NREQ) : 1;
    localparam int SW = (P_SCAN > 1) ? $clog2(P_SCAN) : 1;
    localparam int HW = (P_HOLD > 1) ? $clog2(P_HOLD) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(P_SCAN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(P_HOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [SW-1:0]     scan_cnt;
    logic              scan_tick;
    logic [HW-1:0]     hold_cnt;
    logic              hold_clr;
    logic [PW-1:0]     rr_ptr;
    logic [P_NREQ-1:0] others_req;
    logic [P_NREQ-1:0] pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_vld;
    logic              pick_take;
    logic              owner_req;
    logic [P_NREQ-1:0] gnt_nxt;
    logic [7:0]        owner_bcd;
    logic [6:0]        tens_enc;
    logic [6:0]        ones_enc;
    logic [6:0]        seg_tens;
    logic [6:0]        seg_ones;

    // The owner is masked out so any pick is always a different requester.
    assign others_req = i_req & ~o_gnt;
    assign owner_req  = |(i_req & o_gnt);

    rr_pick #(
        .P_NREQ (P_NREQ),
        .P_PW   (PW)
    ) u_rr_pick (
        .req   (others_req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_vld)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            o_gnt  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            o_gnt <= gnt_nxt;
            if (pick_take) begin
                rr_ptr <= pick_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = o_gnt;
        hold_clr  = 1'b0;
        pick_take = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt   = pick_gnt;
                    pick_take = 1'b1;
                    hold_clr  = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // A drop takes priority over hold expiry in the same cycle.
                if (!owner_req) begin
                    if (pick_vld) begin
                        gnt_nxt   = pick_gnt;
                        pick_take = 1'b1;
                        hold_clr  = 1'b1;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_OPEN;
                end
            end
            S_OPEN: begin
                if (pick_vld) begin
                    gnt_nxt   = pick_gnt;
                    pick_take = 1'b1;
                    hold_clr  = 1'b1;
                    state_nxt = S_HOLD;
                end else if (!owner_req) begin
                    gnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_cnt <= '0;
        end else if (hold_clr) begin
            hold_cnt <= '0;
        end else if (state == S_HOLD && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign scan_tick = (scan_cnt == SCAN_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scan_cnt <= '0;
            o_sel    <= 1'b0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            o_sel    <= ~o_sel;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Value is taken from the owner-to-be so a new grant and its digits appear together.
    always_comb begin
        owner_bcd = '0;
        for (int k = 0; k < P_NREQ; k++) begin
            if (gnt_nxt[k]) begin
                owner_bcd = owner_bcd | i_bcd[8*k +: 8];
            end
        end
    end

    always_comb begin
        tens_enc = SEG_BLANK;
        ones_enc = SEG_BLANK;
        if (|gnt_nxt) begin
`ifdef DISP_LZ_BLANK_EN
            tens_enc = (owner_bcd[7:4] == 4'd0) ? SEG_BLANK : bcd_to_seg(owner_bcd[7:4]);
`else
            tens_enc = bcd_to_seg(owner_bcd[7:4]);
`endif
            ones_enc = bcd_to_seg(owner_bcd[3:0]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seg_tens <= SEG_BLANK;
            seg_ones <= SEG_BLANK;
        end else if (scan_tick || (gnt_nxt != o_gnt)) begin
            seg_tens <= tens_enc;
            seg_ones <= ones_enc;
        end
    end

    assign o_busy        = |o_gnt;
    assign o_digitalTube = o_sel ? seg_tens : seg_ones;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with P_NREQ=4, P_SCAN=4, P_HOLD=16.
module tb_seg_display_arbiter;

    localparam int NREQ = 4;
    localparam int NV   = 7;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [31:0]     bcd;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [6:0]      tube;
    logic            sel;

    int total;
    int passed;

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] bcd;
        logic [3:0]  gnt;
        logic [6:0]  tens;
        logic [6:0]  ones;
    } vec_t;

    vec_t vec [NV];

    seg_display_arbiter #(
        .P_NREQ (NREQ),
        .P_SCAN (4),
        .P_HOLD (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_bcd         (bcd),
        .o_gnt         (gnt),
        .o_busy        (busy),
        .o_digitalTube (tube),
        .o_sel         (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic do_reset(input logic [3:0] r, input logic [31:0] b);
        @(negedge clk);
        rst = 1'b1;
        req = r;
        bcd = b;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic get_digits(output logic [6:0] t, output logic [6:0] o);
        int n;
        n = 0;
        while (sel !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        t = tube;
        n = 0;
        while (sel !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        o = tube;
    endtask

    logic [6:0] t_seg, o_seg;
    logic [6:0] exp_tens0;
    int         cnt;
    int         runlen;
    int         changes;
    logic [3:0] cur;
    logic [3:0] rot_seq [5];

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        req    = '0;
        bcd    = '0;
`ifdef DISP_LZ_BLANK_EN
        exp_tens0 = 7'h7F;
`else
        exp_tens0 = 7'b0000001;
`endif
        vec[0] = '{req: 4'b0000, bcd: 32'h0000_0000, gnt: 4'b0000, tens: 7'h7F,      ones: 7'h7F};
        vec[1] = '{req: 4'b0010, bcd: 32'h0000_3700, gnt: 4'b0010, tens: 7'b0000110, ones: 7'b0001111};
        vec[2] = '{req: 4'b0001, bcd: 32'h0000_0005, gnt: 4'b0001, tens: exp_tens0,  ones: 7'b0100100};
        vec[3] = '{req: 4'b0001, bcd: 32'h0000_00A5, gnt: 4'b0001, tens: 7'b1111110, ones: 7'b0100100};
        vec[4] = '{req: 4'b1100, bcd: 32'h9812_0000, gnt: 4'b0100, tens: 7'b1001111, ones: 7'b0010010};
        vec[5] = '{req: 4'b1001, bcd: 32'h6400_0077, gnt: 4'b1000, tens: 7'b0100000, ones: 7'b1001100};
        vec[6] = '{req: 4'b0001, bcd: 32'h0000_009F, gnt: 4'b0001, tens: 7'b0000100, ones: 7'b1111110};

        // reset state while reset is held
        #3;
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_sel", {31'h0, sel}, 32'h0);
        chk("rst_tube", {25'h0, tube}, 32'h7F);

        // idle scanning: o_sel toggles every 4 cycles, display stays blank
        do_reset(4'b0000, 32'h0);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("idle_sel_k%0d", k), {31'h0, sel}, ((k / 4) % 2));
            chk($sformatf("idle_tube_k%0d", k), {25'h0, tube}, 32'h7F);
        end
        chk("idle_gnt", {28'h0, gnt}, 32'h0);

        // table-driven single-request vectors, fresh reset each
        for (int i = 0; i < NV; i++) begin
            do_reset(vec[i].req, vec[i].bcd);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), {28'h0, gnt}, {28'h0, vec[i].gnt});
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, |vec[i].gnt});
            get_digits(t_seg, o_seg);
            chk($sformatf("vec%0d_tens", i), {25'h0, t_seg}, {25'h0, vec[i].tens});
            chk($sformatf("vec%0d_ones", i), {25'h0, o_seg}, {25'h0, vec[i].ones});
        end

        // minimum hold: late requester waits for expiry
        do_reset(4'b0010, 32'h0045_3700);
        @(negedge clk);
        chk("hold_first", {28'h0, gnt}, 32'h2);
        cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (gnt === 4'b0010) cnt++;
            if (k == 3) req = 4'b0110;
        end
        chk("hold_kept_cycles", cnt, 16);
        @(negedge clk);
        chk("hold_switch", {28'h0, gnt}, 32'h4);
        get_digits(t_seg, o_seg);
        chk("hold_new_tens", {25'h0, t_seg}, {25'h0, 7'b1001100});
        chk("hold_new_ones", {25'h0, o_seg}, {25'h0, 7'b0100100});

        // asynchronous reset in the middle of a cycle clears the grant at once
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gnt", {28'h0, gnt}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_tube", {25'h0, tube}, 32'h7F);
        chk("midrst_sel", {31'h0, sel}, 32'h0);

        // owner drops during hold with another request: regrant, hold restarts
        do_reset(4'b0010, 32'h0000_0000);
        @(negedge clk);
        chk("drop_first", {28'h0, gnt}, 32'h2);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("drop_regrant", {28'h0, gnt}, 32'h8);
        req = 4'b1001;
        cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (gnt === 4'b1000) cnt++;
        end
        chk("drop_hold_restart", cnt, 16);
        @(negedge clk);
        chk("drop_next_owner", {28'h0, gnt}, 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("release_gnt", {28'h0, gnt}, 32'h0);
        chk("release_busy", {31'h0, busy}, 32'h0);
        get_digits(t_seg, o_seg);
        chk("release_tens", {25'h0, t_seg}, 32'h7F);
        chk("release_ones", {25'h0, o_seg}, 32'h7F);

        // all requesting: rotation 1,2,3,0,1 each held at least P_HOLD cycles
        rot_seq[0] = 4'b0010;
        rot_seq[1] = 4'b0100;
        rot_seq[2] = 4'b1000;
        rot_seq[3] = 4'b0001;
        rot_seq[4] = 4'b0010;
        do_reset(4'b1111, 32'h1122_3344);
        @(negedge clk);
        chk("rot_start", {28'h0, gnt}, {28'h0, rot_seq[0]});
        cur     = gnt;
        runlen  = 1;
        changes = 0;
        for (int c = 0; c < 150 && changes < 4; c++) begin
            @(negedge clk);
            if (gnt !== cur) begin
                chk($sformatf("rot_len%0d", changes), {31'h0, (runlen >= 16 && runlen <= 17)}, 32'h1);
                changes++;
                chk($sformatf("rot_owner%0d", changes), {28'h0, gnt}, {28'h0, rot_seq[changes]});
                cur    = gnt;
                runlen = 1;
            end else begin
                runlen++;
            end
        end
        chk("rot_changes", changes, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
